// File: rtl/stencil_pkg.sv
// Shared types, default sizes and helpers for the stencil window generator.
package stencil_pkg;

    localparam int unsigned DEFAULT_MAX_WIDTH      = 1024;
    localparam int unsigned DEFAULT_MAX_HEIGHT     = 1024;
    localparam int unsigned DEFAULT_PIXEL_BITWIDTH = 8;
    localparam int unsigned DEFAULT_CHANNELS       = 3;
    localparam int unsigned DEFAULT_KERNEL_SIZE    = 3;

    localparam int unsigned DEFAULT_COL_W    = $clog2(DEFAULT_MAX_WIDTH);
    localparam int unsigned DEFAULT_ROW_W    = $clog2(DEFAULT_MAX_HEIGHT);
    localparam int unsigned DEFAULT_WIDTH_W  = $clog2(DEFAULT_MAX_WIDTH + 1);
    localparam int unsigned DEFAULT_HEIGHT_W = $clog2(DEFAULT_MAX_HEIGHT + 1);

    typedef logic [DEFAULT_PIXEL_BITWIDTH-1:0] pixel_t;
    typedef pixel_t [DEFAULT_CHANNELS-1:0]     pixel_vec_t;

    // Clamp a runtime frame dimension into [lo, hi].
    function automatic int unsigned clamp_dim(input int unsigned value,
                                              input int unsigned lo,
                                              input int unsigned hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/stencil_line_mem.sv
// One line of pixel storage: async read, clocked write, read-before-write.
module stencil_line_mem
    import stencil_pkg::*;
#(
    parameter  int unsigned DEPTH  = DEFAULT_MAX_WIDTH,
    parameter  int unsigned DATA_W = DEFAULT_CHANNELS * DEFAULT_PIXEL_BITWIDTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Read returns the old contents during a write to the same address.
    assign rd_data_o = mem_q[addr_i];

    // Storage is deliberately not reset; validity gating hides stale data.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/stencil_window_gen.sv
// KERNEL_SIZE x KERNEL_SIZE sliding window generator over a raster stream.
// Optional coordinate outputs o_col/o_row: define STENCIL_WINDOW_GEN_COORD_EN.
module stencil_window_gen
    import stencil_pkg::*;
#(
    parameter  int unsigned MAX_WIDTH      = DEFAULT_MAX_WIDTH,
    parameter  int unsigned MAX_HEIGHT     = DEFAULT_MAX_HEIGHT,
    parameter  int unsigned PIXEL_BITWIDTH = DEFAULT_PIXEL_BITWIDTH,
    parameter  int unsigned CHANNELS       = DEFAULT_CHANNELS,
    parameter  int unsigned KERNEL_SIZE    = DEFAULT_KERNEL_SIZE,
    localparam int unsigned WIDTH_W        = $clog2(MAX_WIDTH + 1),
    localparam int unsigned HEIGHT_W       = $clog2(MAX_HEIGHT + 1),
    localparam int unsigned COL_W          = $clog2(MAX_WIDTH),
    localparam int unsigned ROW_W          = $clog2(MAX_HEIGHT)
) (
    input  logic                                   clk,
    input  logic                                   n_rst,
    input  logic [WIDTH_W-1:0]                     i_width,
    input  logic [HEIGHT_W-1:0]                    i_height,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    input  logic [CHANNELS-1:0][PIXEL_BITWIDTH-1:0] i_data,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic [CHANNELS-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIXEL_BITWIDTH-1:0] o_data,
    output logic                                   o_eof
`ifdef STENCIL_WINDOW_GEN_COORD_EN
    ,
    output logic [COL_W-1:0]                       o_col,
    output logic [ROW_W-1:0]                       o_row
`endif
);

    localparam int unsigned LINES = KERNEL_SIZE - 1;
    localparam int unsigned PIX_W = CHANNELS * PIXEL_BITWIDTH;

    typedef logic [CHANNELS-1:0][PIXEL_BITWIDTH-1:0] vec_t;
    typedef logic [CHANNELS-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIXEL_BITWIDTH-1:0] win_t;

    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [WIDTH_W-1:0]  width_q, width_d;
    logic [HEIGHT_W-1:0] height_q, height_d;
    logic                valid_q, valid_d;
    logic                eof_q, eof_d;
    win_t                win_q, win_d;

    logic                accept;
    logic                first_pix;
    logic                last_col;
    logic                last_row;
    logic                qualify;
    logic [WIDTH_W-1:0]  width_clamped;
    logic [HEIGHT_W-1:0] height_clamped;
    logic [WIDTH_W-1:0]  eff_width;
    logic [HEIGHT_W-1:0] eff_height;

    vec_t line_rd [LINES];
    vec_t line_wr [LINES];
    vec_t col_vec [KERNEL_SIZE];

    // Stall only when a window is pending and downstream refuses it.
    assign o_ready = !(valid_q && !i_ready);
    assign accept  = i_valid && o_ready;

    // Frame geometry: the first pixel uses the live (clamped) inputs.
    assign width_clamped  = WIDTH_W'(clamp_dim(32'(i_width), KERNEL_SIZE, MAX_WIDTH));
    assign height_clamped = HEIGHT_W'(clamp_dim(32'(i_height), KERNEL_SIZE, MAX_HEIGHT));
    assign first_pix      = (col_q == '0) && (row_q == '0);
    assign eff_width      = first_pix ? width_clamped : width_q;
    assign eff_height     = first_pix ? height_clamped : height_q;
    assign last_col       = (WIDTH_W'(col_q) == (eff_width - 1'b1));
    assign last_row       = (HEIGHT_W'(row_q) == (eff_height - 1'b1));
    assign qualify        = (row_q >= ROW_W'(LINES)) && (col_q >= COL_W'(LINES));

    // Line memory chain; line j holds the row that is j+1 lines old.
    for (genvar j = 0; j < LINES; j++) begin : g_line
        if (j == 0) begin : g_head
            assign line_wr[j] = i_data;
        end else begin : g_tail
            assign line_wr[j] = line_rd[j-1];
        end

        stencil_line_mem #(
            .DEPTH  (MAX_WIDTH),
            .DATA_W (PIX_W)
        ) u_line (
            .clk       (clk),
            .addr_i    (col_q),
            .we_i      (accept),
            .wr_data_i (line_wr[j]),
            .rd_data_o (line_rd[j])
        );

        assign col_vec[j] = line_rd[LINES-1-j];
    end
    assign col_vec[LINES] = i_data;

    // Next-state: counters, frame latch, window shift and output qualifiers.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        width_d  = width_q;
        height_d = height_q;
        valid_d  = valid_q;
        eof_d    = eof_q;
        win_d    = win_q;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (first_pix) begin
                width_d  = width_clamped;
                height_d = height_clamped;
            end

            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            for (int ch = 0; ch < CHANNELS; ch++) begin
                for (int r = 0; r < KERNEL_SIZE; r++) begin
                    for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                        win_d[ch][r][c] = win_q[ch][r][c+1];
                    end
                    win_d[ch][r][KERNEL_SIZE-1] = col_vec[r][ch];
                end
            end

            valid_d = qualify;
            eof_d   = qualify && last_col && last_row;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            col_q    <= '0;
            row_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            valid_q  <= 1'b0;
            eof_q    <= 1'b0;
            win_q    <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            width_q  <= width_d;
            height_q <= height_d;
            valid_q  <= valid_d;
            eof_q    <= eof_d;
            win_q    <= win_d;
        end
    end

    assign o_valid = valid_q;
    assign o_eof   = eof_q;
    assign o_data  = win_q;

`ifdef STENCIL_WINDOW_GEN_COORD_EN
    logic [COL_W-1:0] coord_col_q, coord_col_d;
    logic [ROW_W-1:0] coord_row_q, coord_row_d;

    // Bottom-right coordinate captured with each emitted window.
    always_comb begin
        coord_col_d = coord_col_q;
        coord_row_d = coord_row_q;
        if (accept && qualify) begin
            coord_col_d = col_q;
            coord_row_d = row_q;
        end
    end

    // Coordinate registers, held with o_data under stall.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            coord_col_q <= '0;
            coord_row_q <= '0;
        end else begin
            coord_col_q <= coord_col_d;
            coord_row_q <= coord_row_d;
        end
    end

    assign o_col = coord_col_q;
    assign o_row = coord_row_q;
`endif

endmodule

// File: tb/tb_stencil_window_gen.sv
// Directed bench for stencil_window_gen: a K=3/CH=1 instance and a K=5/CH=3 instance.
module tb_stencil_window_gen;

    typedef logic [0:0][2:0][2:0][7:0] awin_t;
    typedef logic [2:0][4:0][4:0][7:0] bwin_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;

    logic [4:0]      a_i_width, a_i_height;
    logic            a_i_valid, a_o_ready, a_o_valid, a_i_ready, a_o_eof;
    logic [0:0][7:0] a_i_data;
    awin_t           a_o_data;

    logic [4:0]      b_i_width, b_i_height;
    logic            b_i_valid, b_o_ready, b_o_valid, b_i_ready, b_o_eof;
    logic [2:0][7:0] b_i_data;
    bwin_t           b_o_data;

`ifdef STENCIL_WINDOW_GEN_COORD_EN
    logic [3:0] a_o_col, a_o_row, b_o_col, b_o_row;
`endif

    stencil_window_gen #(
        .MAX_WIDTH(16), .MAX_HEIGHT(16), .PIXEL_BITWIDTH(8), .CHANNELS(1), .KERNEL_SIZE(3)
    ) u_dut_a (
        .clk(clk), .n_rst(n_rst), .i_width(a_i_width), .i_height(a_i_height),
        .i_valid(a_i_valid), .o_ready(a_o_ready), .i_data(a_i_data),
        .o_valid(a_o_valid), .i_ready(a_i_ready), .o_data(a_o_data), .o_eof(a_o_eof)
`ifdef STENCIL_WINDOW_GEN_COORD_EN
        , .o_col(a_o_col), .o_row(a_o_row)
`endif
    );

    stencil_window_gen #(
        .MAX_WIDTH(16), .MAX_HEIGHT(16), .PIXEL_BITWIDTH(8), .CHANNELS(3), .KERNEL_SIZE(5)
    ) u_dut_b (
        .clk(clk), .n_rst(n_rst), .i_width(b_i_width), .i_height(b_i_height),
        .i_valid(b_i_valid), .o_ready(b_o_ready), .i_data(b_i_data),
        .o_valid(b_o_valid), .i_ready(b_i_ready), .o_data(b_o_data), .o_eof(b_o_eof)
`ifdef STENCIL_WINDOW_GEN_COORD_EN
        , .o_col(b_o_col), .o_row(b_o_row)
`endif
    );

    int errors = 0;
    int checks = 0;
    int stuck  = 0;
    int cyc    = 0;
    int a_in_cnt = 0;
    int b_in_cnt = 0;

    awin_t a_win[$];
    logic  a_eof[$];
    int    a_win_cyc[$];
    int    a_in_cyc[$];
    bwin_t b_win[$];
    logic  b_eof[$];
`ifdef STENCIL_WINDOW_GEN_COORD_EN
    int    a_coord[$];
`endif

    // Expected K=3 window with bottom-right pixel (R,C); pixel = base + row*16 + col.
    function automatic awin_t a_exp(input int base, input int rr, input int cc);
        awin_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[0][r][c] = 8'(base + (rr - 2 + r) * 16 + (cc - 2 + c));
        return w;
    endfunction

    // Expected K=5 window; sample = ch*64 + row*8 + col.
    function automatic bwin_t b_exp(input int rr, input int cc);
        bwin_t w;
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    w[ch][r][c] = 8'(ch * 64 + (rr - 4 + r) * 8 + (cc - 4 + c));
        return w;
    endfunction

    // One clock: observe handshakes at the falling edge, then advance.
    task automatic step();
        @(negedge clk);
        if (a_i_valid && a_o_ready) begin
            a_in_cnt++;
            a_in_cyc.push_back(cyc);
        end
        if (a_o_valid && a_i_ready) begin
            a_win.push_back(a_o_data);
            a_eof.push_back(a_o_eof);
            a_win_cyc.push_back(cyc);
`ifdef STENCIL_WINDOW_GEN_COORD_EN
            a_coord.push_back(int'(a_o_row) * 16 + int'(a_o_col));
`endif
        end
        if (b_i_valid && b_o_ready) b_in_cnt++;
        if (b_o_valid && b_i_ready) begin
            b_win.push_back(b_o_data);
            b_eof.push_back(b_o_eof);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [7:0] v);
        int start;
        int n;
        start = a_in_cnt;
        n = 0;
        a_i_data[0] = v;
        a_i_valid   = 1'b1;
        while (a_in_cnt == start && n < 50) begin
            step();
            n++;
        end
        if (a_in_cnt == start) stuck++;
        a_i_valid = 1'b0;
    endtask

    task automatic a_frame(input int base, input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                a_send(8'(base + r * 16 + c));
    endtask

    task automatic a_drain();
        a_i_valid = 1'b0;
        repeat (4) step();
    endtask

    task automatic a_clear();
        a_win.delete();
        a_eof.delete();
        a_win_cyc.delete();
        a_in_cyc.delete();
`ifdef STENCIL_WINDOW_GEN_COORD_EN
        a_coord.delete();
`endif
        stuck = 0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) step();
        n_rst = 1'b1;
        step();
        checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_o_valid); end
        checks++; if (a_o_eof !== 1'b0) begin errors++; $display("FAIL reset_eof: got %b want 0", a_o_eof); end
        checks++; if (a_o_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", a_o_data); end
        checks++; if (a_o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", a_o_ready); end
        checks++; if (b_o_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b want 0", b_o_valid); end
        checks++; if (b_o_data !== '0) begin errors++; $display("FAIL reset_b_data: nonzero after reset"); end
`ifdef STENCIL_WINDOW_GEN_COORD_EN
        checks++; if ({a_o_col, a_o_row} !== 8'h00) begin errors++; $display("FAIL reset_coord: got %h want 00", {a_o_col, a_o_row}); end
`endif
    endtask

    task automatic test_basic();
        a_clear();
        a_i_width = 5'd4; a_i_height = 5'd3; a_i_ready = 1'b1;
        a_frame(0, 4, 3);
        a_drain();
        checks++; if (stuck !== 0) begin errors++; $display("FAIL basic_stuck: got %0d want 0", stuck); end
        checks++; if (a_win.size() !== 2) begin errors++; $display("FAIL basic_count: got %0d want 2", a_win.size()); end
        if (a_win.size() == 2) begin
            checks++; if (a_win[0] !== a_exp(0, 2, 2)) begin errors++; $display("FAIL basic_win0: got %h want %h", a_win[0], a_exp(0, 2, 2)); end
            checks++; if (a_win[1] !== a_exp(0, 2, 3)) begin errors++; $display("FAIL basic_win1: got %h want %h", a_win[1], a_exp(0, 2, 3)); end
            checks++; if ({a_eof[0], a_eof[1]} !== 2'b01) begin errors++; $display("FAIL basic_eof: got %b%b want 01", a_eof[0], a_eof[1]); end
            checks++; if (a_in_cyc.size() != 12 || a_win_cyc[0] !== a_in_cyc[10] + 1) begin
                errors++; $display("FAIL basic_latency: window cycle %0d, pixel 0x22 cycle %0d", a_win_cyc[0], a_in_cyc[10]);
            end
`ifdef STENCIL_WINDOW_GEN_COORD_EN
            checks++; if (a_coord[0] !== 2 * 16 + 2) begin errors++; $display("FAIL basic_coord: got %0d want 34", a_coord[0]); end
`endif
        end
    endtask

    task automatic test_stall();
        int held;
        a_clear();
        a_i_width = 5'd4; a_i_height = 5'd3; a_i_ready = 1'b0;
        for (int i = 0; i < 11; i++) a_send(8'((i / 4) * 16 + (i % 4)));
        a_i_data[0] = 8'h23;
        a_i_valid   = 1'b1;
        held = a_in_cnt;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (a_o_valid !== 1'b1 || a_o_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hs[%0d]: valid=%b ready=%b want 1/0", k, a_o_valid, a_o_ready);
            end
            checks++; if (a_o_data !== a_exp(0, 2, 2)) begin errors++; $display("FAIL stall_data[%0d]: got %h want %h", k, a_o_data, a_exp(0, 2, 2)); end
            checks++; if (a_in_cnt !== held) begin errors++; $display("FAIL stall_consumed[%0d]: got %0d want %0d", k, a_in_cnt, held); end
        end
        a_i_ready = 1'b1;
        a_send(8'h23);
        a_drain();
        checks++; if (stuck !== 0 || a_win.size() !== 2) begin errors++; $display("FAIL stall_count: got %0d stuck %0d want 2", a_win.size(), stuck); end
        if (a_win.size() == 2) begin
            checks++; if (a_win[0] !== a_exp(0, 2, 2)) begin errors++; $display("FAIL stall_win0: got %h want %h", a_win[0], a_exp(0, 2, 2)); end
            checks++; if (a_win[1] !== a_exp(0, 2, 3) || a_eof[1] !== 1'b1) begin
                errors++; $display("FAIL stall_win1: got %h eof %b want %h eof 1", a_win[1], a_eof[1], a_exp(0, 2, 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        awin_t exp_w [5];
        logic  exp_e [5];
        a_clear();
        a_i_ready = 1'b1; a_i_width = 5'd4; a_i_height = 5'd3;
        a_frame(0, 4, 3);
        a_i_width = 5'd5;
        a_frame(8'h80, 5, 3);
        a_drain();
        exp_w[0] = a_exp(0, 2, 2);     exp_e[0] = 1'b0;
        exp_w[1] = a_exp(0, 2, 3);     exp_e[1] = 1'b1;
        exp_w[2] = a_exp(8'h80, 2, 2); exp_e[2] = 1'b0;
        exp_w[3] = a_exp(8'h80, 2, 3); exp_e[3] = 1'b0;
        exp_w[4] = a_exp(8'h80, 2, 4); exp_e[4] = 1'b1;
        checks++; if (stuck !== 0 || a_win.size() !== 5) begin errors++; $display("FAIL b2b_count: got %0d stuck %0d want 5", a_win.size(), stuck); end
        for (int i = 0; i < 5 && i < a_win.size(); i++) begin
            checks++; if (a_win[i] !== exp_w[i] || a_eof[i] !== exp_e[i]) begin
                errors++; $display("FAIL b2b_win[%0d]: got %h eof %b want %h eof %b", i, a_win[i], a_eof[i], exp_w[i], exp_e[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        a_clear();
        a_i_ready = 1'b1; a_i_width = 5'd4; a_i_height = 5'd3;
        for (int i = 0; i < 7; i++) a_send(8'(8'h40 + (i / 4) * 16 + (i % 4)));
        n_rst = 1'b0;
        repeat (2) step();
        checks++; if (a_o_valid !== 1'b0 || a_o_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_state: valid=%b ready=%b want 0/1", a_o_valid, a_o_ready);
        end
        n_rst = 1'b1;
        a_frame(0, 4, 3);
        a_drain();
        checks++; if (stuck !== 0 || a_win.size() !== 2) begin errors++; $display("FAIL midrst_count: got %0d stuck %0d want 2", a_win.size(), stuck); end
        if (a_win.size() == 2) begin
            checks++; if (a_win[0] !== a_exp(0, 2, 2) || a_win[1] !== a_exp(0, 2, 3)) begin
                errors++; $display("FAIL midrst_win: got %h %h want %h %h", a_win[0], a_win[1], a_exp(0, 2, 2), a_exp(0, 2, 3));
            end
            checks++; if ({a_eof[0], a_eof[1]} !== 2'b01) begin errors++; $display("FAIL midrst_eof: got %b%b want 01", a_eof[0], a_eof[1]); end
        end
    endtask

    task automatic test_clamp();
        a_clear();
        a_i_ready = 1'b1; a_i_width = 5'd2; a_i_height = 5'd3;
        a_frame(0, 3, 3);
        a_drain();
        checks++; if (stuck !== 0 || a_win.size() !== 1) begin errors++; $display("FAIL clamp_count: got %0d stuck %0d want 1", a_win.size(), stuck); end
        if (a_win.size() == 1) begin
            checks++; if (a_win[0] !== a_exp(0, 2, 2) || a_eof[0] !== 1'b1) begin
                errors++; $display("FAIL clamp_win: got %h eof %b want %h eof 1", a_win[0], a_eof[0], a_exp(0, 2, 2));
            end
        end
    endtask

    task automatic test_random_k5();
        int start;
        int n;
        int idx;
        int bstuck;
        bstuck = 0;
        b_win.delete();
        b_eof.delete();
        b_i_width = 5'd8; b_i_height = 5'd7;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 8; c++) begin
                b_i_valid = 1'b0;
                b_i_ready = 1'($urandom_range(0, 1));
                step();
                for (int ch = 0; ch < 3; ch++) b_i_data[ch] = 8'(ch * 64 + r * 8 + c);
                b_i_valid = 1'b1;
                start = b_in_cnt;
                n = 0;
                while (b_in_cnt == start && n < 50) begin
                    b_i_ready = 1'($urandom_range(0, 1));
                    step();
                    n++;
                end
                if (b_in_cnt == start) bstuck++;
            end
        end
        b_i_valid = 1'b0;
        b_i_ready = 1'b1;
        repeat (4) step();
        checks++; if (bstuck !== 0 || b_win.size() !== 12) begin errors++; $display("FAIL k5_count: got %0d stuck %0d want 12", b_win.size(), bstuck); end
        idx = 0;
        for (int rr = 4; rr < 7; rr++) begin
            for (int cc = 4; cc < 8; cc++) begin
                if (idx < b_win.size()) begin
                    checks++; if (b_win[idx] !== b_exp(rr, cc)) begin
                        errors++; $display("FAIL k5_win[%0d]: got %h want %h", idx, b_win[idx], b_exp(rr, cc));
                    end
                    checks++; if (b_eof[idx] !== ((rr == 6 && cc == 7) ? 1'b1 : 1'b0)) begin
                        errors++; $display("FAIL k5_eof[%0d]: got %b", idx, b_eof[idx]);
                    end
                end
                idx++;
            end
        end
    endtask

    initial begin
        n_rst = 1'b0;
        a_i_width = 5'd4; a_i_height = 5'd3; a_i_valid = 1'b0; a_i_ready = 1'b1; a_i_data = '0;
        b_i_width = 5'd8; b_i_height = 5'd7; b_i_valid = 1'b0; b_i_ready = 1'b1; b_i_data = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_clamp();
        test_random_k5();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
